// File: rtl/adpll_tx_serializer.sv
// Transmit serializer for adpll_ctr: buffers packet bytes in a small FIFO, sends a
// preamble and then the bytes LSB-first on data_mod, one bit every SYM_CYCLES clocks.
module adpll_tx_serializer #(
   parameter int unsigned SYM_CYCLES     = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter logic [7:0]  PREAMBLE       = 8'hAA,
   parameter int unsigned PREAMBLE_BYTES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] adpll_mode,
   input  logic       channel_lock,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       data_mod,
   output logic       sym_strobe,
   output logic       tx_busy,
   output logic       underrun,
   output logic       tx_abort
);

   localparam int unsigned SC_W  = $clog2(SYM_CYCLES);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BIT_W = $clog2(8 * PREAMBLE_BYTES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PRE  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_TAIL = 2'd3;

   localparam logic [SC_W-1:0]  SYM_LAST  = SC_W'(SYM_CYCLES - 1);
   localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(8 * PREAMBLE_BYTES - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   // FIFO storage and pointers
   logic [8:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Serializer state
   logic [1:0]       r_state;
   logic [SC_W-1:0]  r_sym_cnt;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [6:0]       r_shreg;
   logic             r_cur_last;
   logic             r_data_mod;
   logic             r_strobe;
   logic             r_busy;
   logic             r_underrun;
   logic             r_abort;

   logic             w_go;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_fsm_flush;
   logic [8:0]       w_head;
   logic             w_wrap;
   logic [SC_W-1:0]  w_sym_inc;
   logic [BIT_W-1:0] w_bit_inc;

   logic [1:0]       w_state_nxt;
   logic [SC_W-1:0]  w_sym_cnt_nxt;
   logic [BIT_W-1:0] w_bit_cnt_nxt;
   logic [6:0]       w_shreg_nxt;
   logic             w_cur_last_nxt;
   logic             w_data_mod_nxt;
   logic             w_strobe_nxt;
   logic             w_underrun_nxt;
   logic             w_abort_nxt;

   assign w_go      = en & (adpll_mode == 2'd3) & channel_lock;
   assign w_empty   = (r_count == {CNT_W{1'b0}});
   assign tx_ready  = rst & en & (r_count < FIFO_FULL);
   assign w_push    = tx_valid & tx_ready;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_flush   = ~en | w_fsm_flush;
   assign w_wrap    = (r_sym_cnt == SYM_LAST);
   assign w_sym_inc = w_wrap ? {SC_W{1'b0}} : (r_sym_cnt + SC_W'(1));
   assign w_bit_inc = r_bit_cnt + BIT_W'(1);

   assign data_mod   = r_data_mod;
   assign sym_strobe = r_strobe;
   assign tx_busy    = r_busy;
   assign underrun   = r_underrun;
   assign tx_abort   = r_abort;

   // Next-state logic: symbol timing, preamble/data bit selection, abort and underrun
   always_comb begin
      w_state_nxt    = r_state;
      w_sym_cnt_nxt  = w_sym_inc;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shreg_nxt    = r_shreg;
      w_cur_last_nxt = r_cur_last;
      w_data_mod_nxt = r_data_mod;
      w_strobe_nxt   = 1'b0;
      w_underrun_nxt = 1'b0;
      w_abort_nxt    = 1'b0;
      w_pop          = 1'b0;
      w_fsm_flush    = 1'b0;

      if ((r_state != ST_IDLE) && !w_go) begin
         // losing en, TX mode or lock kills the frame and drops any queued bytes
         w_state_nxt    = ST_IDLE;
         w_sym_cnt_nxt  = {SC_W{1'b0}};
         w_bit_cnt_nxt  = {BIT_W{1'b0}};
         w_data_mod_nxt = 1'b0;
         w_abort_nxt    = 1'b1;
         w_fsm_flush    = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_data_mod_nxt = 1'b0;
               w_sym_cnt_nxt  = {SC_W{1'b0}};
               if (w_go && !w_empty) begin
                  w_state_nxt    = ST_PRE;
                  w_bit_cnt_nxt  = {BIT_W{1'b0}};
                  w_data_mod_nxt = PREAMBLE[0];
                  w_strobe_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_PRE: begin
               if (!w_wrap) begin
                  w_state_nxt = ST_PRE;
               end else if (r_bit_cnt != PRE_LAST) begin
                  w_bit_cnt_nxt  = w_bit_inc;
                  w_data_mod_nxt = PREAMBLE[w_bit_inc[2:0]];
                  w_strobe_nxt   = 1'b1;
               end else if (!w_empty) begin
                  w_pop          = 1'b1;
                  w_state_nxt    = ST_DATA;
                  w_bit_cnt_nxt  = {BIT_W{1'b0}};
                  w_shreg_nxt    = w_head[7:1];
                  w_cur_last_nxt = w_head[8];
                  w_data_mod_nxt = w_head[0];
                  w_strobe_nxt   = 1'b1;
               end else begin
                  w_state_nxt    = ST_TAIL;
                  w_data_mod_nxt = 1'b0;
                  w_underrun_nxt = 1'b1;
                  w_strobe_nxt   = 1'b1;
               end
            end
            ST_DATA: begin
               if (!w_wrap) begin
                  w_state_nxt = ST_DATA;
               end else if (r_bit_cnt[2:0] != 3'd7) begin
                  w_bit_cnt_nxt  = w_bit_inc;
                  w_data_mod_nxt = r_shreg[0];
                  w_shreg_nxt    = {1'b0, r_shreg[6:1]};
                  w_strobe_nxt   = 1'b1;
               end else if (r_cur_last) begin
                  w_state_nxt    = ST_TAIL;
                  w_data_mod_nxt = 1'b0;
                  w_strobe_nxt   = 1'b1;
               end else if (!w_empty) begin
                  // back-to-back bytes: next byte's bit 0 follows with no gap
                  w_pop          = 1'b1;
                  w_bit_cnt_nxt  = {BIT_W{1'b0}};
                  w_shreg_nxt    = w_head[7:1];
                  w_cur_last_nxt = w_head[8];
                  w_data_mod_nxt = w_head[0];
                  w_strobe_nxt   = 1'b1;
               end else begin
                  w_state_nxt    = ST_TAIL;
                  w_data_mod_nxt = 1'b0;
                  w_underrun_nxt = 1'b1;
                  w_strobe_nxt   = 1'b1;
               end
            end
            ST_TAIL: begin
               w_data_mod_nxt = 1'b0;
               if (w_wrap) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_TAIL;
               end
            end
            default: begin
               w_state_nxt    = ST_IDLE;
               w_data_mod_nxt = 1'b0;
            end
         endcase
      end
   end

   // Serializer registers and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_sym_cnt  <= {SC_W{1'b0}};
         r_bit_cnt  <= {BIT_W{1'b0}};
         r_shreg    <= 7'd0;
         r_cur_last <= 1'b0;
         r_data_mod <= 1'b0;
         r_strobe   <= 1'b0;
         r_busy     <= 1'b0;
         r_underrun <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sym_cnt  <= w_sym_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shreg    <= w_shreg_nxt;
         r_cur_last <= w_cur_last_nxt;
         r_data_mod <= w_data_mod_nxt;
         r_strobe   <= w_strobe_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_underrun <= w_underrun_nxt;
         r_abort    <= w_abort_nxt;
      end
   end

   // Byte FIFO; a flush wins over a simultaneous push
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 9'd0;
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else if (w_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {tx_last, tx_data};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_adpll_tx_serializer.sv
// Self-checking bench for adpll_tx_serializer: directed frame table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_adpll_tx_serializer;

   localparam int SYM   = 32;
   localparam int DEPTH = 4;
   localparam int PB    = 1;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] adpll_mode;
   logic       channel_lock;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic       data_mod;
   logic       sym_strobe;
   logic       tx_busy;
   logic       underrun;
   logic       tx_abort;

   adpll_tx_serializer #(
      .SYM_CYCLES(SYM), .FIFO_DEPTH(DEPTH), .PREAMBLE(8'hAA), .PREAMBLE_BYTES(PB)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .adpll_mode(adpll_mode), .channel_lock(channel_lock),
      .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .data_mod(data_mod), .sym_strobe(sym_strobe), .tx_busy(tx_busy),
      .underrun(underrun), .tx_abort(tx_abort)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: byte queue, queue of bits still to send, symbol countdown
   logic [8:0] m_fifo[$];
   bit         m_bits[$];
   bit         m_busy, m_dm, m_str, m_und, m_abt, m_tail, m_in_data, m_cur_last;
   int         m_left;
   logic [7:0] pre_pat = 8'hAA;

   int          mon_busy, mon_ns, mon_und, mon_abt;
   logic [63:0] mon_bits;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [16:0] exp_bits;
      int          exp_busy;
      int          exp_und;
   } vec_t;
   vec_t vecs[4];

   logic [7:0] burst[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_ready();
      return rst && en && (m_fifo.size() < DEPTH);
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_bits.delete();
      m_busy = 0; m_dm = 0; m_str = 0; m_und = 0; m_abt = 0;
      m_tail = 0; m_in_data = 0; m_cur_last = 0; m_left = 0;
   endtask

   task automatic model_update();
      bit go, push, flush;
      logic [8:0] b;
      logic [8:0] pv;
      if (!rst) begin
         model_reset();
         return;
      end
      go    = en && (adpll_mode == 2'd3) && channel_lock;
      push  = tx_valid && m_ready();
      pv    = {tx_last, tx_data};
      flush = !en;
      m_str = 0; m_und = 0; m_abt = 0;
      if (!m_busy) begin
         m_dm = 0;
         if (go && m_fifo.size() > 0) begin
            m_busy = 1; m_tail = 0; m_in_data = 0;
            m_bits.delete();
            for (int i = 0; i < 8 * PB; i++) m_bits.push_back(pre_pat[i % 8]);
            m_dm = m_bits.pop_front();
            m_str = 1;
            m_left = SYM - 1;
         end
      end else if (!go) begin
         m_busy = 0; m_dm = 0; m_abt = 1; m_tail = 0; flush = 1;
         m_bits.delete();
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         m_left = SYM - 1;
         if (m_bits.size() > 0) begin
            m_dm = m_bits.pop_front(); m_str = 1;
         end else if (m_tail) begin
            m_busy = 0; m_dm = 0; m_tail = 0;
         end else if (m_in_data && m_cur_last) begin
            m_tail = 1; m_dm = 0; m_str = 1;
         end else if (m_fifo.size() > 0) begin
            b = m_fifo.pop_front();
            m_cur_last = b[8];
            m_in_data = 1;
            for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
            m_dm = m_bits.pop_front(); m_str = 1;
         end else begin
            m_und = 1; m_tail = 1; m_dm = 0; m_str = 1;
         end
      end
      if (flush) m_fifo.delete();
      else if (push) m_fifo.push_back(pv);
   endtask

   task automatic clear_mon();
      mon_busy = 0; mon_ns = 0; mon_und = 0; mon_abt = 0; mon_bits = 64'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("cycle_outputs",
            64'({data_mod, sym_strobe, tx_busy, underrun, tx_abort, tx_ready}),
            64'({m_dm, m_str, m_busy, m_und, m_abt, m_ready()}));
      if (tx_busy) mon_busy++;
      if (sym_strobe) begin
         if (mon_ns < 64) mon_bits[mon_ns] = data_mod;
         mon_ns++;
      end
      if (underrun) mon_und++;
      if (tx_abort) mon_abt++;
   endtask

   task automatic run_frame(input int budget);
      bit seen;
      int n;
      seen = 0;
      n = 0;
      while (n < budget) begin
         tick();
         n++;
         if (tx_busy) seen = 1;
         else if (seen) break;
      end
      check("frame_complete", 64'({seen, tx_busy}), 64'(2'b10));
   endtask

   task automatic wait_strobes(input int target, input int budget);
      int n;
      n = 0;
      while (mon_ns < target && n < budget) begin
         tick();
         n++;
      end
      check("strobe_wait", 64'(mon_ns >= target), 64'(1));
   endtask

   // Ticks until the model says the next edge pops a byte from the FIFO
   task automatic wait_pop(input int budget);
      int n;
      n = 0;
      while (!(m_busy && !m_tail && m_left == 0 && m_bits.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      check("pop_window_found", 64'(n < budget), 64'(1));
   endtask

   task automatic push_one(input logic [7:0] d, input logic l);
      tx_valid = 1'b1; tx_data = d; tx_last = l;
      tick();
      tx_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 17'h05AAA, 544, 0};
      vecs[1] = '{8'hFF, 1'b0, 17'h0FFAA, 544, 1};
      vecs[2] = '{8'h00, 1'b1, 17'h000AA, 544, 0};
      vecs[3] = '{8'h81, 1'b1, 17'h081AA, 544, 0};
      burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      rst = 1'b0; en = 1'b1; adpll_mode = 2'd3; channel_lock = 1'b1;
      tx_data = 8'd0; tx_last = 1'b0; tx_valid = 1'b1;
      model_reset();
      clear_mon();
      repeat (3) tick();
      check("reset_state", 64'({data_mod, sym_strobe, tx_busy, underrun, tx_abort, tx_ready}), 64'd0);
      tx_valid = 1'b0;
      rst = 1'b1;
      tick();

      // Single-byte frames: preamble + byte + tail, with and without tx_last
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         push_one(vecs[i].data, vecs[i].last);
         run_frame(2000);
         check("tbl_bits", mon_bits, 64'(vecs[i].exp_bits));
         check("tbl_busy_cycles", 64'(mon_busy), 64'(vecs[i].exp_busy));
         check("tbl_underrun", 64'(mon_und), 64'(vecs[i].exp_und));
         check("tbl_strobes", 64'(mon_ns), 64'(17));
         check("tbl_abort", 64'(mon_abt), 64'd0);
      end

      // FIFO fills while in RX mode, then drains as one contiguous frame
      adpll_mode = 2'd2;
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1'b1; tx_data = burst[i]; tx_last = (i == 3);
         tick();
         if (i >= 3) check("ready_low_when_full", 64'(tx_ready), 64'd0);
      end
      tx_valid = 1'b0;
      adpll_mode = 2'd3;
      clear_mon();
      run_frame(3000);
      check("burst_bits", mon_bits, 64'h0000_0044_3322_11AA);
      check("burst_busy_cycles", 64'(mon_busy), 64'd1312);
      check("burst_strobes", 64'(mon_ns), 64'd41);
      check("burst_underrun", 64'(mon_und), 64'd0);

      // Lock lost during data bit 3 aborts the frame and flushes the queued byte
      clear_mon();
      push_one(8'hA5, 1'b0);
      push_one(8'h3C, 1'b1);
      wait_strobes(12, 1000);
      repeat (5) tick();
      channel_lock = 1'b0;
      tick();
      check("abort_pulse", 64'({tx_abort, data_mod, tx_busy, tx_ready}), 64'(4'b1001));
      tick();
      check("abort_single_cycle", 64'(tx_abort), 64'd0);
      check("abort_count", 64'(mon_abt), 64'd1);
      check("abort_no_underrun", 64'(mon_und), 64'd0);
      channel_lock = 1'b1;
      clear_mon();
      repeat (100) tick();
      check("idle_after_flush", 64'(mon_busy), 64'd0);

      // Asynchronous reset in the middle of the preamble
      clear_mon();
      push_one(8'h96, 1'b1);
      wait_strobes(3, 500);
      repeat (7) tick();
      #2 rst = 1'b0;
      #1 check("async_reset_outputs",
               64'({data_mod, tx_busy, sym_strobe, underrun, tx_abort, tx_ready}), 64'd0);
      repeat (3) tick();
      rst = 1'b1;
      clear_mon();
      repeat (100) tick();
      check("no_tx_after_reset", 64'(mon_busy), 64'd0);
      clear_mon();
      push_one(8'h96, 1'b1);
      run_frame(2000);
      check("post_reset_bits", mon_bits, 64'h0000_0000_0000_96AA);

      // Three-byte packet with pushes landing on the same edges as pops
      clear_mon();
      push_one(8'h01, 1'b0);
      wait_pop(1000);
      push_one(8'h80, 1'b0);
      wait_pop(1000);
      push_one(8'hC3, 1'b1);
      run_frame(2000);
      check("pkt3_bits", mon_bits, 64'h0000_0000_C380_01AA);
      check("pkt3_strobes", 64'(mon_ns), 64'd33);
      check("pkt3_busy_cycles", 64'(mon_busy), 64'd1056);
      check("pkt3_underrun", 64'(mon_und), 64'd0);

      // Randomized traffic with occasional lock, enable and mode glitches
      for (int c = 0; c < 6000; c++) begin
         tx_valid     = ($urandom_range(0, 3) == 0);
         tx_data      = 8'($urandom);
         tx_last      = ($urandom_range(0, 3) == 0);
         channel_lock = ($urandom_range(0, 1499) != 0);
         en           = ($urandom_range(0, 2999) != 0);
         adpll_mode   = ($urandom_range(0, 1999) == 0) ? 2'd2 : 2'd3;
         tick();
      end
      tx_valid = 1'b0;
      en = 1'b1; channel_lock = 1'b1; adpll_mode = 2'd3;
      repeat (1500) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
